// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file arbiter slice.
// Contents: default data/address widths, the owner encoding used by the
// arbiter mux, and the width of the debug starvation counter.
// Optional feature macro used elsewhere in this slice: DBG_LOCK_EN.
package regfile_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int STARVE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Bus bundle between the requesters (core controller, host debug port), the
// arbiter and the 16x8 register file.
// Signals: core_req/we/addr/wdata -> core_gnt/core_stall;
//          dbg_req/we/addr/wdata (+ dbg_lock when DBG_LOCK_EN) -> dbg_gnt,
//          dbg_rdata, dbg_rvalid;
//          rf_addr/rf_wdata/rf_load to the register file, rf_rdata back.
// Modports: master = requester/register-file side, slave = arbiter.
interface regfile_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
`ifdef DBG_LOCK_EN
    logic              dbg_lock;
`endif
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_load;
    logic [DATA_W-1:0] rf_rdata;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
`ifdef DBG_LOCK_EN
        output dbg_lock,
`endif
        output rf_rdata,
        input  core_gnt, core_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
        input  rf_addr, rf_wdata, rf_load
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
`ifdef DBG_LOCK_EN
        input  dbg_lock,
`endif
        input  rf_rdata,
        output core_gnt, core_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
        output rf_addr, rf_wdata, rf_load
    );

endinterface

// File: rtl/regfile_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive cycles in which the debug
// port was denied. sat flags that the count reached STARVE_MAX, which forces
// the next debug request through.
// Ports: clk, CLB (sync active-low reset), inc (count a denied cycle),
//        clr (clear, dominates inc), sat (count == STARVE_MAX).
module arb_starve_ctr
    import regfile_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic CLB,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v == LIMIT) ? v : v + STARVE_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!CLB) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign sat = (cnt == LIMIT);

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the register file between the core controller and
// a host debug port. Core has fixed priority; after STARVE_MAX consecutive
// denied debug cycles the debug port is forced through for one access.
// Debug reads are returned registered (dbg_rdata/dbg_rvalid, latency 1);
// core reads come straight from the register file.
// Ports: clk, CLB (sync active-low reset), bus (regfile_arbiter_if.slave).
// Optional macro DBG_LOCK_EN: adds dbg_lock; once a locked debug grant is
// taken the core is held off until dbg_lock drops (atomic host burst).
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               CLB,
    regfile_arbiter_if.slave   bus
);
    owner_e            owner;
    logic              core_gnt;
    logic              dbg_gnt;
    logic              starve_sat;
    logic              starve_inc;
    logic              starve_clr;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .CLB (CLB),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (starve_sat)
    );

`ifdef DBG_LOCK_EN
    logic lock_q;

    // Dropping dbg_lock releases the lock even in a cycle with a grant.
    always_ff @(posedge clk) begin
        if (!CLB) begin
            lock_q <= 1'b0;
        end else if (!bus.dbg_lock) begin
            lock_q <= 1'b0;
        end else if (dbg_gnt) begin
            lock_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        dbg_gnt  = bus.dbg_req && (!bus.core_req || starve_sat);
        core_gnt = bus.core_req && !dbg_gnt;
`ifdef DBG_LOCK_EN
        if (lock_q) begin
            dbg_gnt  = bus.dbg_req;
            core_gnt = 1'b0;
        end
`endif
    end

    assign starve_inc = bus.dbg_req && !dbg_gnt;
    assign starve_clr = !starve_inc;

    always_comb begin
        owner = OWN_NONE;
        if (dbg_gnt) begin
            owner = OWN_DBG;
        end else if (core_gnt) begin
            owner = OWN_CORE;
        end
    end

    always_comb begin
        bus.rf_addr  = '0;
        bus.rf_wdata = '0;
        bus.rf_load  = 1'b0;
        case (owner)
            OWN_CORE: begin
                bus.rf_addr  = bus.core_addr;
                bus.rf_wdata = bus.core_wdata;
                bus.rf_load  = bus.core_we;
            end
            OWN_DBG: begin
                bus.rf_addr  = bus.dbg_addr;
                bus.rf_wdata = bus.dbg_wdata;
                bus.rf_load  = bus.dbg_we;
            end
            default: ;
        endcase
    end

    // Stage p1: debug read capture, one cycle after the grant
    always_ff @(posedge clk) begin
        if (!CLB) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= dbg_gnt && !bus.dbg_we;
            if (dbg_gnt && !bus.dbg_we) begin
                rdata_p1 <= bus.rf_rdata;
            end
        end
    end

    assign bus.core_gnt   = core_gnt;
    assign bus.core_stall = bus.core_req && !core_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.dbg_rdata  = rdata_p1;
    assign bus.dbg_rvalid = vld_p1;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model of the
// arbitration rules and a shadow copy of the register file.
module tb_regfile_arbiter;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic clb;
    always #5 clk = ~clk;

    regfile_arbiter_if bus ();

    regfile_arbiter #(
        .STARVE_MAX (SMAX)
    ) dut (
        .clk (clk),
        .CLB (clb),
        .bus (bus)
    );

    // Register file stand-in: synchronous write, combinational read.
    logic [7:0] rf [16];
    always_ff @(posedge clk) begin
        if (bus.rf_load) rf[bus.rf_addr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata = rf[bus.rf_addr];

    // Reference model state
    logic [7:0] ref_mem [16];
    int         denied;
    logic       e_rvalid;
    logic [7:0] e_rdata;
    logic       lock_m;
    logic       last_dgnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [3:0] caddr,
                         input logic [7:0] cwd, input logic dreq, input logic dwe,
                         input logic [3:0] daddr, input logic [7:0] dwd);
        bus.core_req   = creq;
        bus.core_we    = cwe;
        bus.core_addr  = caddr;
        bus.core_wdata = cwd;
        bus.dbg_req    = dreq;
        bus.dbg_we     = dwe;
        bus.dbg_addr   = daddr;
        bus.dbg_wdata  = dwd;
    endtask

    // One clock: check everything against the model, then advance the model.
    // Entered just after a falling edge with inputs already applied.
    task automatic cycle();
        logic       eg_d, eg_c, el;
        logic [3:0] ea;
        logic [7:0] ew, rd_val;
        #1;
        eg_d = bus.dbg_req && (lock_m || !bus.core_req || denied == SMAX);
        eg_c = bus.core_req && !lock_m && !eg_d;
        ea = 4'h0; ew = 8'h00; el = 1'b0;
        if (eg_d) begin
            ea = bus.dbg_addr; ew = bus.dbg_wdata; el = bus.dbg_we;
        end else if (eg_c) begin
            ea = bus.core_addr; ew = bus.core_wdata; el = bus.core_we;
        end
        chk("core_gnt", bus.core_gnt, eg_c);
        chk("dbg_gnt", bus.dbg_gnt, eg_d);
        chk("core_stall", bus.core_stall, bus.core_req && !eg_c);
        chk("rf_addr", bus.rf_addr, ea);
        chk("rf_wdata", bus.rf_wdata, ew);
        chk("rf_load", bus.rf_load, el);
        chk("dbg_rvalid", bus.dbg_rvalid, e_rvalid);
        chk("dbg_rdata", bus.dbg_rdata, e_rdata);
        if (eg_c && !bus.core_we) chk("core_rd", bus.rf_rdata, ref_mem[bus.core_addr]);
        rd_val = ref_mem[bus.dbg_addr];
        @(posedge clk);
        if (el) ref_mem[ea] = ew;
        last_dgnt = eg_d;
        if (!clb) begin
            denied = 0; e_rvalid = 1'b0; e_rdata = 8'h00; lock_m = 1'b0;
        end else begin
            e_rvalid = eg_d && !bus.dbg_we;
            if (e_rvalid) e_rdata = rd_val;
            if (bus.dbg_req && !eg_d) denied = (denied + 1 > SMAX) ? SMAX : denied + 1;
            else denied = 0;
`ifdef DBG_LOCK_EN
            if (!bus.dbg_lock) lock_m = 1'b0;
            else if (eg_d) lock_m = 1'b1;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        logic pend;
        clb = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DBG_LOCK_EN
        bus.dbg_lock = 1'b0;
`endif
        denied = 0; e_rvalid = 0; e_rdata = 0; lock_m = 0; last_dgnt = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        @(posedge clk); @(posedge clk); @(negedge clk);

        // Reset state
        cycle();
        cycle();
        clb = 1'b1;

        // Clear the register file through the core port
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 4'(i), 8'h00, 0, 0, 0, 0);
            cycle();
        end

        // Core write alone, then read back
        drive(1, 1, 4'd3, 8'hA5, 0, 0, 0, 0);
        #1 chk("cw_gnt", bus.core_gnt, 1'b1);
        chk("cw_load", bus.rf_load, 1'b1);
        chk("cw_addr", bus.rf_addr, 4'd3);
        cycle();
        drive(1, 0, 4'd3, 8'h00, 0, 0, 0, 0);
        #1 chk("cr_a5", bus.rf_rdata, 8'hA5);
        cycle();

        // Debug read alone of preloaded reg 5
        drive(1, 1, 4'd5, 8'h3C, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 0, 4'd5, 0);
        #1 chk("dr_gnt", bus.dbg_gnt, 1'b1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("dr_vld1", bus.dbg_rvalid, 1'b1);
        chk("dr_data", bus.dbg_rdata, 8'h3C);
        cycle();
        #1 chk("dr_vld0", bus.dbg_rvalid, 1'b0);
        cycle();

        // Starvation: both held, debug forced in cycle 4, core again in 5
        drive(1, 0, 4'd0, 0, 1, 0, 4'd1, 0);
        for (int i = 0; i < 6; i++) begin
            #1 chk("st_dgnt", bus.dbg_gnt, (i == 4));
            chk("st_cgnt", bus.core_gnt, (i != 4));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Simultaneous writes to reg 7: core wins
        drive(1, 1, 4'd7, 8'h11, 1, 1, 4'd7, 8'h22);
        #1 chk("sw_cgnt", bus.core_gnt, 1'b1);
        chk("sw_wdata", bus.rf_wdata, 8'h11);
        cycle();
        drive(1, 0, 4'd7, 0, 0, 0, 0, 0);
        #1 chk("sw_rd", bus.rf_rdata, 8'h11);
        cycle();

        // Reset during a debug read grant, with the starve count non-zero
        drive(1, 0, 4'd2, 0, 1, 0, 4'd5, 0);
        cycle();
        cycle();
        drive(0, 0, 0, 0, 1, 0, 4'd5, 0);
        clb = 1'b0;
        cycle();
        clb = 1'b1;
        drive(1, 0, 4'd2, 0, 1, 0, 4'd5, 0);
        #1 chk("rs_vld", bus.dbg_rvalid, 1'b0);
        chk("rs_data", bus.dbg_rdata, 8'h00);
        chk("rs_cgnt", bus.core_gnt, 1'b1);
        chk("rs_rf5", rf[5], 8'h3C);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

`ifdef DBG_LOCK_EN
        // Locked burst holds the core off until dbg_lock drops
        drive(0, 0, 0, 0, 1, 1, 4'd9, 8'h5A);
        bus.dbg_lock = 1'b1;
        cycle();
        drive(1, 0, 4'd1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lk_cgnt", bus.core_gnt, 1'b0);
            chk("lk_stall", bus.core_stall, 1'b1);
            cycle();
        end
        bus.dbg_lock = 1'b0;
        cycle();
        #1 chk("lk_rel", bus.core_gnt, 1'b1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
`endif

        // Random traffic; debug request held until granted
        pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bus.core_req   = ($urandom % 2) == 0;
            bus.core_we    = ($urandom % 2) == 0;
            bus.core_addr  = 4'($urandom_range(15));
            bus.core_wdata = 8'($urandom);
            if (!pend && ($urandom % 3) == 0) begin
                pend          = 1'b1;
                bus.dbg_req   = 1'b1;
                bus.dbg_we    = ($urandom % 2) == 0;
                bus.dbg_addr  = 4'($urandom_range(15));
                bus.dbg_wdata = 8'($urandom);
            end else if (!pend) begin
                bus.dbg_req = 1'b0;
            end
`ifdef DBG_LOCK_EN
            bus.dbg_lock = ($urandom % 4) == 0;
`endif
            clb = ($urandom % 50) != 0;
            cycle();
            if (last_dgnt) pend = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
